// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and sign-magnitude field layout
package fft_pkg;
  localparam int FFT_N = 8;
  localparam int FFT_W = 24;
  localparam logic [FFT_W-1:0] CT_0707 = 24'h00b4fd;
  localparam int SIGN_BIT = FFT_W - 1;
  localparam int MAG_MSB = FFT_W - 2;
endpackage

// File: rtl/fft_out_serializer_if.sv
// fft_out_serializer_if: frame capture handshake plus sample stream handshake
interface fft_out_serializer_if
  import fft_pkg::*;
#(
  parameter int W = FFT_W
);
  logic [W-1:0] a0r, a1r, a2r, a3r, a4r, a5r, a6r, a7r;
  logic [W-1:0] a0i, a1i, a2i, a3i, a4i, a5i, a6i, a7i;
  logic in_valid, in_ready;
  logic [W-1:0] out_re, out_im;
  logic [2:0] out_idx;
  logic out_last, out_valid, out_ready;
  modport master (
    output a0r, a1r, a2r, a3r, a4r, a5r, a6r, a7r,
    output a0i, a1i, a2i, a3i, a4i, a5i, a6i, a7i,
    output in_valid, out_ready,
    input  in_ready, out_re, out_im, out_idx, out_last, out_valid
  );
  modport slave (
    input  a0r, a1r, a2r, a3r, a4r, a5r, a6r, a7r,
    input  a0i, a1i, a2i, a3i, a4i, a5i, a6i, a7i,
    input  in_valid, out_ready,
    output in_ready, out_re, out_im, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/fft_sm2tc.sv
// fft_sm2tc: sign-magnitude to output-format converter, negative zero folded to 0
module fft_sm2tc #(
  parameter int W = 24,
  parameter bit OUT_TWOS = 1'b1
) (
  input  logic [W-1:0] i_sm,
  output logic [W-1:0] o_val
);
  logic [W-1:0] w_mag;
  logic w_neg;
  assign w_mag = {1'b0, i_sm[W-2:0]};
  assign w_neg = i_sm[W-1] & (|i_sm[W-2:0]);
  assign o_val = !w_neg ? w_mag : OUT_TWOS ? '0 - w_mag : i_sm;
endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures whole 8-bin FFT frames into a ping-pong buffer
// and streams them out one complex sample per beat in natural bin order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int W = FFT_W,
  parameter bit OUT_TWOS = 1'b1
) (
  input logic clk,
  input logic rst_n,
  fft_out_serializer_if.slave bus
);
  logic [W-1:0] w_raw_re [FFT_N];
  logic [W-1:0] w_raw_im [FFT_N];
  logic [W-1:0] w_cv_re [FFT_N];
  logic [W-1:0] w_cv_im [FFT_N];
  logic [W-1:0] r_re [2][FFT_N];
  logic [W-1:0] r_im [2][FFT_N];
  logic r_wr_bank, r_rd_bank;
  logic [1:0] r_count;
  logic [2:0] r_rd_idx;
  logic w_cap, w_beat, w_last;
  assign w_raw_re[0] = bus.a0r;
  assign w_raw_re[1] = bus.a1r;
  assign w_raw_re[2] = bus.a2r;
  assign w_raw_re[3] = bus.a3r;
  assign w_raw_re[4] = bus.a4r;
  assign w_raw_re[5] = bus.a5r;
  assign w_raw_re[6] = bus.a6r;
  assign w_raw_re[7] = bus.a7r;
  assign w_raw_im[0] = bus.a0i;
  assign w_raw_im[1] = bus.a1i;
  assign w_raw_im[2] = bus.a2i;
  assign w_raw_im[3] = bus.a3i;
  assign w_raw_im[4] = bus.a4i;
  assign w_raw_im[5] = bus.a5i;
  assign w_raw_im[6] = bus.a6i;
  assign w_raw_im[7] = bus.a7i;
  for (genvar g = 0; g < FFT_N; g++) begin : g_cv
    fft_sm2tc #(.W(W), .OUT_TWOS(OUT_TWOS)) u_re (.i_sm(w_raw_re[g]), .o_val(w_cv_re[g]));
    fft_sm2tc #(.W(W), .OUT_TWOS(OUT_TWOS)) u_im (.i_sm(w_raw_im[g]), .o_val(w_cv_im[g]));
  end
  assign bus.in_ready = r_count != 2'd2;
  assign bus.out_valid = r_count != 2'd0;
  assign bus.out_re = r_re[r_rd_bank][r_rd_idx];
  assign bus.out_im = r_im[r_rd_bank][r_rd_idx];
  assign bus.out_idx = r_rd_idx;
  assign bus.out_last = r_rd_idx == 3'd7;
  assign w_cap = bus.in_valid & bus.in_ready;
  assign w_beat = bus.out_valid & bus.out_ready;
  assign w_last = w_beat & (r_rd_idx == 3'd7);
  // a capture and a frame release in the same cycle cancel in the occupancy count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_count <= 2'd0;
      r_rd_idx <= 3'd0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < FFT_N; k++) begin
          r_re[b][k] <= '0;
          r_im[b][k] <= '0;
        end
    end else begin
      if (w_cap) begin
        r_wr_bank <= ~r_wr_bank;
        for (int k = 0; k < FFT_N; k++) begin
          r_re[r_wr_bank][k] <= w_cv_re[k];
          r_im[r_wr_bank][k] <= w_cv_im[k];
        end
      end
      if (w_beat) r_rd_idx <= r_rd_idx + 3'd1;
      if (w_last) r_rd_bank <= ~r_rd_bank;
      r_count <= r_count + {1'b0, w_cap} - {1'b0, w_last};
    end
endmodule
